alu_share_arbiter: RTL and testbench

//   Shares a single combinational ALU (5-bit ctrl, two 32-bit sources, result + zero)

---
 rtl/alu_share_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU between two
// requesters; one operation in flight, result held until the owner accepts it.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [CTRL_W-1:0] req0_ctrl_i,
    input  logic [DATA_W-1:0] req0_src1_i,
    input  logic [DATA_W-1:0] req0_src2_i,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [CTRL_W-1:0] req1_ctrl_i,
    input  logic [DATA_W-1:0] req1_src1_i,
    input  logic [DATA_W-1:0] req1_src2_i,

    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [DATA_W-1:0] rsp0_result_o,
    output logic              rsp0_zero_o,

    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp1_result_o,
    output logic              rsp1_zero_o,

    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic              owner;
    logic              last_grant;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;

    logic              any_req;
    logic              grant;
    logic              owner_rsp_ready;

    // When both requesters contend, the one not served last wins.
    always_comb begin
        any_req = req0_valid_i | req1_valid_i;
        grant   = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant = ~last_grant;
        end else if (req1_valid_i) begin
            grant = 1'b1;
        end
    end

    assign owner_rsp_ready = owner ? rsp1_ready_i : rsp0_ready_i;

    assign req0_ready_o = (state == IDLE) && any_req && (grant == 1'b0);
    assign req1_ready_o = (state == IDLE) && any_req && (grant == 1'b1);

    assign rsp0_valid_o  = (state == RESP) && (owner == 1'b0);
    assign rsp1_valid_o  = (state == RESP) && (owner == 1'b1);
    assign rsp0_result_o = result_q;
    assign rsp1_result_o = result_q;
    assign rsp0_zero_o   = zero_q;
    assign rsp1_zero_o   = zero_q;

    assign alu_ctrl_o = ctrl_q;
    assign alu_src1_o = src1_q;
    assign alu_src2_o = src2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            ctrl_q     <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner  <= grant;
                        ctrl_q <= grant ? req1_ctrl_i : req0_ctrl_i;
                        src1_q <= grant ? req1_src1_i : req0_src1_i;
                        src2_q <= grant ? req1_src2_i : req0_src2_i;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= alu_result_i;
                    zero_q   <= alu_zero_i;
                    state    <= RESP;
                end
                RESP: begin
                    if (owner_rsp_ready) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small reference ALU hooked to the shared port.
module tb_alu_share_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [4:0]  req0_ctrl_i, req1_ctrl_i;
    logic [31:0] req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i;
    logic        rsp0_valid_o, rsp1_valid_o;
    logic        rsp0_ready_i, rsp1_ready_i;
    logic [31:0] rsp0_result_o, rsp1_result_o;
    logic        rsp0_zero_o, rsp1_zero_o;
    logic [4:0]  alu_ctrl_o;
    logic [31:0] alu_src1_o, alu_src2_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    // Stand-in ALU: 0 add, 1 or, 2 sub, 3 and, 4 xor.
    always_comb begin
        alu_result_i = 32'h0;
        case (alu_ctrl_o)
            5'd0: alu_result_i = alu_src1_o + alu_src2_o;
            5'd1: alu_result_i = alu_src1_o | alu_src2_o;
            5'd2: alu_result_i = alu_src1_o - alu_src2_o;
            5'd3: alu_result_i = alu_src1_o & alu_src2_o;
            5'd4: alu_result_i = alu_src1_o ^ alu_src2_o;
            default: alu_result_i = 32'h0;
        endcase
        alu_zero_i = (alu_result_i == 32'h0);
    end

    alu_share_arbiter #(.DATA_W(32), .CTRL_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_ctrl_i(req0_ctrl_i),
        .req0_src1_i(req0_src1_i), .req0_src2_i(req0_src2_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_ctrl_i(req1_ctrl_i),
        .req1_src1_i(req1_src1_i), .req1_src2_i(req1_src2_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
        .rsp0_result_o(rsp0_result_o), .rsp0_zero_o(rsp0_zero_o),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
        .rsp1_result_o(rsp1_result_o), .rsp1_zero_o(rsp1_zero_o),
        .alu_ctrl_o(alu_ctrl_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i)
    );

    typedef struct {
        bit          sel;
        logic [4:0]  ctrl;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] exp_result;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid_i = 0; req1_valid_i = 0;
        req0_ctrl_i = 0; req0_src1_i = 0; req0_src2_i = 0;
        req1_ctrl_i = 0; req1_src1_i = 0; req1_src2_i = 0;
        rsp0_ready_i = 0; rsp1_ready_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, " ready0"}, {31'h0, req0_ready_o}, 32'h0);
        check({tag, " ready1"}, {31'h0, req1_ready_o}, 32'h0);
        check({tag, " rsp0_valid"}, {31'h0, rsp0_valid_o}, 32'h0);
        check({tag, " rsp1_valid"}, {31'h0, rsp1_valid_o}, 32'h0);
        check({tag, " alu_ctrl"}, {27'h0, alu_ctrl_o}, 32'h0);
        check({tag, " alu_src1"}, alu_src1_o, 32'h0);
        check({tag, " alu_src2"}, alu_src2_o, 32'h0);
    endtask

    // One isolated request: grant at T, EXEC, then response held in RESP.
    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        if (v.sel) begin
            req1_valid_i = 1; req1_ctrl_i = v.ctrl; req1_src1_i = v.src1; req1_src2_i = v.src2;
        end else begin
            req0_valid_i = 1; req0_ctrl_i = v.ctrl; req0_src1_i = v.src1; req0_src2_i = v.src2;
        end
        #1;
        check({t, " ready0"}, {31'h0, req0_ready_o}, {31'h0, !v.sel});
        check({t, " ready1"}, {31'h0, req1_ready_o}, {31'h0, v.sel});
        tick();
        req0_valid_i = 0; req1_valid_i = 0;
        #1;
        check({t, " exec rsp_valid"}, {30'h0, rsp1_valid_o, rsp0_valid_o}, 32'h0);
        check({t, " exec alu_ctrl"}, {27'h0, alu_ctrl_o}, {27'h0, v.ctrl});
        tick();
        check({t, " rsp0_valid"}, {31'h0, rsp0_valid_o}, {31'h0, !v.sel});
        check({t, " rsp1_valid"}, {31'h0, rsp1_valid_o}, {31'h0, v.sel});
        check({t, " result"}, v.sel ? rsp1_result_o : rsp0_result_o, v.exp_result);
        check({t, " zero"}, {31'h0, v.sel ? rsp1_zero_o : rsp0_zero_o}, {31'h0, v.exp_zero});
        if (v.sel) rsp1_ready_i = 1; else rsp0_ready_i = 1;
        tick();
        rsp0_ready_i = 0; rsp1_ready_i = 0;
        #1;
        check({t, " rsp cleared"}, {30'h0, rsp1_valid_o, rsp0_valid_o}, 32'h0);
    endtask

    initial begin
        int grants;
        bit exp_g;
        int budget;

        vecs[0] = '{1'b0, 5'd2, 32'd10, 32'd3, 32'd7, 1'b0};
        vecs[1] = '{1'b1, 5'd2, 32'd7, 32'd7, 32'd0, 1'b1};
        vecs[2] = '{1'b0, 5'd0, 32'd5, 32'd5, 32'd10, 1'b0};
        vecs[3] = '{1'b1, 5'd3, 32'h0000_00F0, 32'h0000_000F, 32'd0, 1'b1};
        vecs[4] = '{1'b1, 5'd1, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0};
        vecs[5] = '{1'b0, 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1};
        vecs[6] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1};

        idle_inputs();
        do_reset();
        #1;
        check_all_quiet("reset");

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Both valid after reset: req0 first, long response stall, then req1.
        do_reset();
        req0_valid_i = 1; req0_ctrl_i = 5'd0; req0_src1_i = 32'd5; req0_src2_i = 32'd5;
        req1_valid_i = 1; req1_ctrl_i = 5'd3; req1_src1_i = 32'hF0; req1_src2_i = 32'h0F;
        #1;
        check("both ready0", {31'h0, req0_ready_o}, 32'h1);
        check("both ready1", {31'h0, req1_ready_o}, 32'h0);
        tick();
        req0_valid_i = 0;
        #1;
        check("exec ready1 held off", {31'h0, req1_ready_o}, 32'h0);
        tick();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d rsp0_valid", c), {31'h0, rsp0_valid_o}, 32'h1);
            check($sformatf("stall%0d result", c), rsp0_result_o, 32'd10);
            check($sformatf("stall%0d zero", c), {31'h0, rsp0_zero_o}, 32'h0);
            check($sformatf("stall%0d ready1", c), {31'h0, req1_ready_o}, 32'h0);
            check($sformatf("stall%0d rsp1_valid", c), {31'h0, rsp1_valid_o}, 32'h0);
            tick();
        end
        rsp0_ready_i = 1;
        tick();
        rsp0_ready_i = 0;
        #1;
        check("second grant ready1", {31'h0, req1_ready_o}, 32'h1);
        check("second grant ready0", {31'h0, req0_ready_o}, 32'h0);
        tick();
        req1_valid_i = 0;
        tick();
        check("req1 rsp_valid", {31'h0, rsp1_valid_o}, 32'h1);
        check("req1 result", rsp1_result_o, 32'd0);
        check("req1 zero", {31'h0, rsp1_zero_o}, 32'h1);
        rsp1_ready_i = 1;
        tick();
        rsp1_ready_i = 0;

        // Continuous contention with always-ready responders alternates grants.
        idle_inputs();
        do_reset();
        req0_valid_i = 1; req0_ctrl_i = 5'd0; req0_src1_i = 32'd1; req0_src2_i = 32'd2;
        req1_valid_i = 1; req1_ctrl_i = 5'd2; req1_src1_i = 32'd9; req1_src2_i = 32'd4;
        rsp0_ready_i = 1; rsp1_ready_i = 1;
        grants = 0;
        exp_g = 1'b0;
        budget = 0;
        #1;
        while (grants < 4 && budget < 40) begin
            if (req0_ready_o && req1_ready_o) begin
                check("alt both ready", 32'h1, 32'h0);
            end else if (req0_ready_o || req1_ready_o) begin
                check($sformatf("alt grant%0d", grants), {31'h0, req1_ready_o}, {31'h0, exp_g});
                exp_g = ~exp_g;
                grants++;
            end
            if (rsp0_valid_o) check("alt rsp0 result", rsp0_result_o, 32'd3);
            if (rsp1_valid_o) check("alt rsp1 result", rsp1_result_o, 32'd5);
            tick();
            budget++;
        end
        check("alt grant count", grants, 4);

        // Reset while an op is in EXEC aborts it without a response.
        idle_inputs();
        do_reset();
        req0_valid_i = 1; req0_ctrl_i = 5'd0; req0_src1_i = 32'd20; req0_src2_i = 32'd22;
        #1;
        check("abort ready0", {31'h0, req0_ready_o}, 32'h1);
        tick();
        req0_valid_i = 0;
        check("abort alu_src1 latched", alu_src1_o, 32'd20);
        rst_i = 1;
        tick();
        rst_i = 0;
        #1;
        check_all_quiet("abort");
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("abort%0d rsp0_valid", c), {31'h0, rsp0_valid_o}, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
